// File: rtl/pspin_feedback_arb_pkg.sv
// Shared PsPIN HER feedback constants used by both the allocator and this arbiter.
// Also carries the saturating counter helper for the statistics outputs.
package pspin_feedback_arb_pkg;

  localparam int HER_ADDR_WIDTH  = 32;
  localparam int HER_LEN_WIDTH   = 20;
  localparam int HER_MSGID_WIDTH = 10;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pspin_feedback_arb_rr.sv
// Round-robin priority select: first requester at or after i_ptr, wrapping.
// Purely combinational; i_ptr must be below NUM_PORTS.
module pspin_rr_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]  i_req,
  input  logic [PORT_WIDTH-1:0] i_ptr,
  output logic [NUM_PORTS-1:0]  o_gnt_oh,
  output logic [PORT_WIDTH-1:0] o_gnt_idx,
  output logic                  o_gnt_vld
);

  int w_pos;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_pos     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_PORTS) w_pos = w_pos - NUM_PORTS;
      if (!o_gnt_vld && i_req[w_pos]) begin
        o_gnt_vld       = 1'b1;
        o_gnt_oh[w_pos] = 1'b1;
        o_gnt_idx       = PORT_WIDTH'(w_pos);
      end
    end
  end

endmodule

// File: rtl/pspin_feedback_arb.sv
// Merges per-cluster HER feedback into one registered stream for the packet allocator,
// round-robin fair, with grant and stall statistics.
module pspin_feedback_arb
  import pspin_feedback_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = HER_ADDR_WIDTH,
  parameter int LEN_WIDTH   = HER_LEN_WIDTH,
  parameter int MSGID_WIDTH = HER_MSGID_WIDTH,
  localparam int PORT_WIDTH = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             s_fb_valid,
  output logic [NUM_PORTS-1:0]             s_fb_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_fb_addr,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]   s_fb_size,
  input  logic [NUM_PORTS*MSGID_WIDTH-1:0] s_fb_msgid,
  output logic                             m_fb_valid,
  input  logic                             m_fb_ready,
  output logic [ADDR_WIDTH-1:0]            m_fb_addr,
  output logic [LEN_WIDTH-1:0]             m_fb_size,
  output logic [MSGID_WIDTH-1:0]           m_fb_msgid,
  output logic [PORT_WIDTH-1:0]            m_fb_port,
  output logic [31:0]                      stat_grants,
  output logic [31:0]                      stat_stall_cycles
);

  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LEN_WIDTH-1:0]   r_size;
  logic [MSGID_WIDTH-1:0] r_msgid;
  logic [PORT_WIDTH-1:0]  r_port;
  logic [PORT_WIDTH-1:0]  r_rr_ptr;
  logic [31:0]            r_grants;
  logic [31:0]            r_stalls;

  logic [NUM_PORTS-1:0]   w_gnt_oh;
  logic [PORT_WIDTH-1:0]  w_gnt_idx;
  logic                   w_gnt_vld;
  logic                   w_load_en;
  logic                   w_grant;
  logic                   w_stall;
  logic [PORT_WIDTH-1:0]  w_ptr_nxt;

  pspin_rr_arb #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_rr_arb (
    .i_req     (s_fb_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // The output slot may reload when empty or being drained this cycle.
  assign w_load_en  = !r_valid || m_fb_ready;
  assign w_grant    = w_load_en && w_gnt_vld && !rst;
  assign w_stall    = r_valid && !m_fb_ready;
  assign s_fb_ready = (w_load_en && !rst) ? w_gnt_oh : '0;
  assign w_ptr_nxt  = (w_gnt_idx == PORT_WIDTH'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PORT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_msgid  <= '0;
      r_port   <= '0;
      r_rr_ptr <= '0;
      r_grants <= '0;
      r_stalls <= '0;
    end else begin
      if (w_load_en) r_valid <= w_gnt_vld;
      if (w_grant) begin
        r_addr   <= s_fb_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        r_size   <= s_fb_size[int'(w_gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
        r_msgid  <= s_fb_msgid[int'(w_gnt_idx)*MSGID_WIDTH +: MSGID_WIDTH];
        r_port   <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
        r_grants <= sat_inc(r_grants);
      end
      if (w_stall) r_stalls <= sat_inc(r_stalls);
    end
  end

  assign m_fb_valid        = r_valid;
  assign m_fb_addr         = r_addr;
  assign m_fb_size         = r_size;
  assign m_fb_msgid        = r_msgid;
  assign m_fb_port         = r_port;
  assign stat_grants       = r_grants;
  assign stat_stall_cycles = r_stalls;

endmodule

// File: tb/tb_pspin_feedback_arb.sv
// Directed scenarios plus a randomized phase, each cycle checked against a
// behavioural model of the arbiter's transfer rules.
module tb_pspin_feedback_arb;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 20;
  localparam int MW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     s_fb_valid;
  logic [NP-1:0]     s_fb_ready;
  logic [NP*AW-1:0]  s_fb_addr;
  logic [NP*LW-1:0]  s_fb_size;
  logic [NP*MW-1:0]  s_fb_msgid;
  logic              m_fb_valid;
  logic              m_fb_ready;
  logic [AW-1:0]     m_fb_addr;
  logic [LW-1:0]     m_fb_size;
  logic [MW-1:0]     m_fb_msgid;
  logic [1:0]        m_fb_port;
  logic [31:0]       stat_grants;
  logic [31:0]       stat_stall_cycles;

  pspin_feedback_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MSGID_WIDTH(MW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_fb_valid        (s_fb_valid),
    .s_fb_ready        (s_fb_ready),
    .s_fb_addr         (s_fb_addr),
    .s_fb_size         (s_fb_size),
    .s_fb_msgid        (s_fb_msgid),
    .m_fb_valid        (m_fb_valid),
    .m_fb_ready        (m_fb_ready),
    .m_fb_addr         (m_fb_addr),
    .m_fb_size         (m_fb_size),
    .m_fb_msgid        (m_fb_msgid),
    .m_fb_port         (m_fb_port),
    .stat_grants       (stat_grants),
    .stat_stall_cycles (stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          md_ptr;
  bit          md_v;
  logic [31:0] md_addr;
  logic [19:0] md_size;
  logic [9:0]  md_msgid;
  int          md_port;
  logic [31:0] md_gr;
  logic [31:0] md_st;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [31:0] a, input logic [19:0] s, input logic [9:0] m);
    s_fb_addr[i*AW +: AW]  = a;
    s_fb_size[i*LW +: LW]  = s;
    s_fb_msgid[i*MW +: MW] = m;
  endtask

  function automatic int pick();
    if (rst) return -1;
    if (md_v && !m_fb_ready) return -1;
    for (int k = 0; k < NP; k++) begin
      if (s_fb_valid[(md_ptr + k) % NP]) return (md_ptr + k) % NP;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_ptr = 0; md_v = 0; md_addr = '0; md_size = '0; md_msgid = '0;
    md_port = 0; md_gr = '0; md_st = '0;
  endtask

  task automatic settle();
    int g;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    g = pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("s_fb_ready", 64'(s_fb_ready), 64'(exp_rdy));
    chk("m_fb_valid", 64'(m_fb_valid), 64'(md_v));
    if (md_v) begin
      chk("m_fb_addr", 64'(m_fb_addr), 64'(md_addr));
      chk("m_fb_size", 64'(m_fb_size), 64'(md_size));
      chk("m_fb_msgid", 64'(m_fb_msgid), 64'(md_msgid));
      chk("m_fb_port", 64'(m_fb_port), 64'(md_port));
    end
    chk("stat_grants", 64'(stat_grants), 64'(md_gr));
    chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(md_st));
  endtask

  task automatic tick();
    int g;
    bit stall;
    g = pick();
    stall = md_v && !m_fb_ready;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (stall && md_st != 32'hFFFF_FFFF) md_st++;
      if (!md_v || m_fb_ready) begin
        if (g >= 0) begin
          md_v     = 1;
          md_addr  = s_fb_addr[g*AW +: AW];
          md_size  = s_fb_size[g*LW +: LW];
          md_msgid = s_fb_msgid[g*MW +: MW];
          md_port  = g;
          md_ptr   = (g + 1) % NP;
          if (md_gr != 32'hFFFF_FFFF) md_gr++;
        end else md_v = 0;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    rst = 1'b1; s_fb_valid = '0; m_fb_ready = 1'b0;
    s_fb_addr = '0; s_fb_size = '0; s_fb_msgid = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) set_port(i, 32'hA000_0000 + 32'(i), 20'(100 + i), 10'(i + 1));

    // all ports continuously valid, sink always ready: 0,1,2,3,0,...
    s_fb_valid = 4'b1111; m_fb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("rr_seq_ready", 64'(s_fb_ready), 64'(1) << (k % 4));
      if (k > 0) chk("rr_seq_port", 64'(m_fb_port), 64'((k - 1) % 4));
      tick();
    end
    s_fb_valid = '0;
    settle();
    chk("grants_after_8", 64'(stat_grants), 64'd8);
    tick();

    // single requester on port 2, exact field pass-through one cycle later
    set_port(2, 32'h1c10_0600, 20'd1536, 10'h2a5);
    s_fb_valid = 4'b0100;
    settle();
    chk("p2_ready", 64'(s_fb_ready), 64'b0100);
    tick();
    s_fb_valid = '0;
    settle();
    chk("p2_valid", 64'(m_fb_valid), 64'd1);
    chk("p2_port", 64'(m_fb_port), 64'd2);
    chk("p2_addr", 64'(m_fb_addr), 64'h1c10_0600);
    chk("p2_size", 64'(m_fb_size), 64'd1536);
    tick();

    // back-pressure for 5 cycles with everyone requesting
    s_fb_valid = 4'b0010;
    step();
    s_fb_valid = 4'b1111; m_fb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_ready", 64'(s_fb_ready), 64'd0);
      chk("stall_port", 64'(m_fb_port), 64'd1);
      chk("stall_addr", 64'(m_fb_addr), 64'hA000_0001);
      tick();
    end
    settle();
    chk("stall_count", 64'(stat_stall_cycles), 64'd5);

    // reset mid-stall drops the held entry; restart favours lowest valid index
    rst = 1'b1;
    tick();
    rst = 1'b0; s_fb_valid = 4'b1010;
    settle();
    chk("rst_valid", 64'(m_fb_valid), 64'd0);
    chk("rst_grants", 64'(stat_grants), 64'd0);
    chk("rst_stalls", 64'(stat_stall_cycles), 64'd0);
    chk("rst_addr", 64'(m_fb_addr), 64'd0);
    chk("rst_first_grant", 64'(s_fb_ready), 64'b0010);
    tick();

    // wrap-around: pointer lands on 3, then ports 0 and 3 compete
    m_fb_ready = 1'b1; s_fb_valid = 4'b0100;
    step();
    s_fb_valid = 4'b1001;
    settle();
    chk("wrap_first", 64'(s_fb_ready), 64'b1000);
    tick();
    settle();
    chk("wrap_second", 64'(s_fb_ready), 64'b0001);
    chk("wrap_port3", 64'(m_fb_port), 64'd3);
    tick();
    s_fb_valid = '0;
    settle();
    chk("wrap_port0", 64'(m_fb_port), 64'd0);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(63) == 0);
      s_fb_valid = NP'($urandom);
      m_fb_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NP; i++) set_port(i, $urandom, 20'($urandom), 10'($urandom));
      step();
    end
    rst = 1'b0; s_fb_valid = '0; m_fb_ready = 1'b1;
    step();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
